// File: rtl/message_build_param.sv
// rtl/message_build_param.sv - parametrised message padder (marker, length field, extra block)
// Optional: define MSG_BUILD_LAST_CHECK_EN to add the sticky err_last output.
module message_build_param #(
   parameter int BLOCK_W = 512,
   parameter int LEN_W   = 64,
   parameter int SIZE_W  = 64
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               en,
   input  logic               sync_rst,
   input  logic [BLOCK_W-1:0] data_in,
   input  logic               data_in_last,
   input  logic               data_in_valid,
   output logic               data_in_ready,
   input  logic [SIZE_W-1:0]  cfg_size,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   output logic [BLOCK_W-1:0] data_out,
   output logic               data_out_last,
   output logic               data_out_valid,
   input  logic               data_out_ready
`ifdef MSG_BUILD_LAST_CHECK_EN
   ,
   output logic               err_last
`endif
);

   localparam int OFF_W = $clog2(BLOCK_W);
   localparam int CNT_W = SIZE_W - OFF_W + 1;
   localparam logic [OFF_W-1:0]   FIT_MAX = OFF_W'(BLOCK_W - LEN_W - 1);
   localparam logic [BLOCK_W-1:0] MSB_BIT = {1'b1, {(BLOCK_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, BODY, LAST, EXTRA} state_t;

   state_t             state_q, state_d;
   logic [SIZE_W-1:0]  size_q, size_d;
   logic [OFF_W-1:0]   rem_q, rem_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ld, ld_last;
   logic [BLOCK_W-1:0] ld_data;

   logic               out_free, in_hs, cfg_hs, fits;
   logic [OFF_W-1:0]   cfg_rem;
   logic [CNT_W-1:0]   cfg_words;
   logic [BLOCK_W-1:0] last_mask, marker, len_blk;

   assign out_free      = !data_out_valid || data_out_ready;
   assign cfg_ready     = en && (state_q == IDLE);
   assign data_in_ready = en && out_free && ((state_q == BODY) || (state_q == LAST));
   assign in_hs         = data_in_valid && data_in_ready;
   assign cfg_hs        = cfg_valid && cfg_ready;

   assign cfg_rem   = cfg_size[OFF_W-1:0];
   assign cfg_words = CNT_W'(cfg_size[SIZE_W-1:OFF_W]) + CNT_W'(cfg_rem != '0);

   // rem==0 means the final word is full: no masking and the marker moves to the extra block
   assign last_mask = (rem_q == '0) ? '1 : ~({BLOCK_W{1'b1}} >> rem_q);
   assign marker    = (rem_q == '0) ? '0 : (MSB_BIT >> rem_q);
   assign len_blk   = BLOCK_W'(size_q);
   assign fits      = (rem_q != '0) && (rem_q <= FIT_MAX);

   always_comb begin
      state_d = state_q;
      size_d  = size_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      ld      = 1'b0;
      ld_last = 1'b0;
      ld_data = '0;
      case (state_q)
         IDLE: begin
            if (cfg_hs) begin
               size_d = cfg_size;
               rem_d  = cfg_rem;
               cnt_d  = cfg_words;
               if (cfg_words == '0)
                  state_d = EXTRA;
               else if (cfg_words == CNT_W'(1))
                  state_d = LAST;
               else
                  state_d = BODY;
            end
         end
         BODY: begin
            if (in_hs) begin
               ld      = 1'b1;
               ld_data = data_in;
               cnt_d   = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(2))
                  state_d = LAST;
            end
         end
         LAST: begin
            if (in_hs) begin
               ld    = 1'b1;
               cnt_d = cnt_q - CNT_W'(1);
               if (fits) begin
                  ld_data = (data_in & last_mask) | marker | len_blk;
                  ld_last = 1'b1;
                  state_d = IDLE;
               end else begin
                  ld_data = (data_in & last_mask) | marker;
                  state_d = EXTRA;
               end
            end
         end
         EXTRA: begin
            if (en && out_free) begin
               ld      = 1'b1;
               ld_data = ((rem_q == '0) ? MSB_BIT : '0) | len_blk;
               ld_last = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         state_q <= IDLE;
      else if (sync_rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         size_q         <= '0;
         rem_q          <= '0;
         cnt_q          <= '0;
         data_out       <= '0;
         data_out_valid <= 1'b0;
         data_out_last  <= 1'b0;
      end else if (sync_rst) begin
         size_q         <= '0;
         rem_q          <= '0;
         cnt_q          <= '0;
         data_out       <= '0;
         data_out_valid <= 1'b0;
         data_out_last  <= 1'b0;
      end else begin
         size_q <= size_d;
         rem_q  <= rem_d;
         cnt_q  <= cnt_d;
         // single output register: only reloads once the current block has drained
         if (out_free) begin
            if (ld) begin
               data_out       <= ld_data;
               data_out_last  <= ld_last;
               data_out_valid <= 1'b1;
            end else begin
               data_out_valid <= 1'b0;
            end
         end
      end
   end

`ifdef MSG_BUILD_LAST_CHECK_EN
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         err_last <= 1'b0;
      else if (sync_rst)
         err_last <= 1'b0;
      else if (in_hs && (data_in_last != (state_q == LAST)))
         err_last <= 1'b1;
   end
`else
   logic unused_last;
   assign unused_last = data_in_last;
`endif

endmodule

// File: tb/tb_message_build_param.sv
// tb/tb_message_build_param.sv - self-checking bench for message_build_param (512/64 and 1024/128)
module tb_message_build_param;

   localparam int BW  = 512;
   localparam int LW  = 64;
   localparam int SW  = 64;
   localparam int BW1 = 1024;
   localparam int LW1 = 128;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   logic en = 1'b1;
   logic sync_rst = 1'b0;
   always #5 clk = ~clk;

   logic [BW-1:0] data_in = '0;
   logic          data_in_last = 1'b0, data_in_valid = 1'b0, data_in_ready;
   logic [SW-1:0] cfg_size = '0;
   logic          cfg_valid = 1'b0, cfg_ready;
   logic [BW-1:0] data_out;
   logic          data_out_last, data_out_valid;
   logic          data_out_ready = 1'b1;

   logic [BW1-1:0] u1_data_in = '0;
   logic           u1_data_in_last = 1'b0, u1_data_in_valid = 1'b0, u1_data_in_ready;
   logic [SW-1:0]  u1_cfg_size = '0;
   logic           u1_cfg_valid = 1'b0, u1_cfg_ready;
   logic [BW1-1:0] u1_data_out;
   logic           u1_data_out_last, u1_data_out_valid;
   logic           u1_data_out_ready = 1'b1;
`ifdef MSG_BUILD_LAST_CHECK_EN
   logic err_last, u1_err_last;
`endif

   message_build_param #(.BLOCK_W(BW), .LEN_W(LW), .SIZE_W(SW)) u0 (
      .clk(clk), .nrst(nrst), .en(en), .sync_rst(sync_rst),
      .data_in(data_in), .data_in_last(data_in_last),
      .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
      .cfg_size(cfg_size), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .data_out(data_out), .data_out_last(data_out_last),
      .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
`ifdef MSG_BUILD_LAST_CHECK_EN
      , .err_last(err_last)
`endif
   );

   message_build_param #(.BLOCK_W(BW1), .LEN_W(LW1), .SIZE_W(SW)) u1 (
      .clk(clk), .nrst(nrst), .en(en), .sync_rst(sync_rst),
      .data_in(u1_data_in), .data_in_last(u1_data_in_last),
      .data_in_valid(u1_data_in_valid), .data_in_ready(u1_data_in_ready),
      .cfg_size(u1_cfg_size), .cfg_valid(u1_cfg_valid), .cfg_ready(u1_cfg_ready),
      .data_out(u1_data_out), .data_out_last(u1_data_out_last),
      .data_out_valid(u1_data_out_valid), .data_out_ready(u1_data_out_ready)
`ifdef MSG_BUILD_LAST_CHECK_EN
      , .err_last(u1_err_last)
`endif
   );

   int vectors = 0;
   int miscompares = 0;
   logic [BW-1:0] msg [0:7];

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [BW-1:0] rand_word();
      logic [BW-1:0] w;
      for (int i = 0; i < BW/32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   // Reference: standard padding of the bit string msg || 1 || 0* || len, cut into blocks
   function automatic logic [BW-1:0] exp_block(input int j, input int size, input int nb);
      logic [BW-1:0] b;
      int p;
      b = '0;
      for (int k = 0; k < BW; k++) begin
         p = j*BW + k;
         if (p < size) b[BW-1-k] = msg[j][BW-1-k];
         else if (p == size) b[BW-1-k] = 1'b1;
      end
      if (j == nb-1) b[LW-1:0] = LW'(size);
      return b;
   endfunction

   task automatic run_msg(input int size, input int mode);
      int words, nb, sent, got, cyc, first_cyc, last_cyc;
      bit saw_rdy;
      words = (size + BW - 1) / BW;
      nb = (size + LW + BW) / BW;
      for (int i = 0; i < 8; i++) msg[i] = rand_word();
      sent = 0; got = 0; cyc = 0; first_cyc = -1; last_cyc = -1; saw_rdy = 0;
      @(negedge clk);
      en = 1'b1; data_in_valid = 1'b0; data_out_ready = 1'b1;
      cfg_size = SW'(size); cfg_valid = 1'b1;
      #1 chk("cfg_ready_idle", cfg_ready, 1'b1);
      @(posedge clk);
      while (got < nb && cyc < 400) begin
         @(negedge clk);
         cfg_valid = 1'b0;
         en = (mode == 0) ? ($urandom_range(0, 9) != 0) : 1'b1;
         data_out_ready = (mode == 1) ? cyc[0] : (mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
         data_in_valid = (sent < words) && ((mode == 2) || ($urandom_range(0, 3) != 0));
         data_in = (sent < words) ? msg[sent] : '0;
         data_in_last = (sent == words - 1);
         #1;
         if (data_in_ready) saw_rdy = 1;
         if (data_out_valid && !data_out_ready) chk("in_ready_while_held", data_in_ready, 1'b0);
         if (!en) begin
            chk("in_ready_en_low", data_in_ready, 1'b0);
            chk("cfg_ready_en_low", cfg_ready, 1'b0);
         end
         if (data_in_valid && data_in_ready) sent++;
         if (data_out_valid && data_out_ready) begin
            chk($sformatf("blk%0d_data_size%0d", got, size), data_out, exp_block(got, size, nb));
            chk($sformatf("blk%0d_last_size%0d", got, size), data_out_last, (got == nb - 1));
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            got++;
         end
         cyc++;
      end
      data_in_valid = 1'b0;
      en = 1'b1;
      chk("blocks_out", got, nb);
      chk("words_in", sent, words);
      if (mode == 2) begin
         chk("first_latency", first_cyc, 1);
         chk("throughput", last_cyc, nb);
      end
      if (words == 0) chk("zero_len_no_ready", saw_rdy, 1'b0);
   endtask

   initial begin
      logic [BW1-1:0] w1, e0, e1;
      int cyc;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_data_out", data_out, '0);
      chk("rst_valid", data_out_valid, 1'b0);
      chk("rst_last", data_out_last, 1'b0);
      chk("rst_cfg_ready", cfg_ready, 1'b1);
      nrst = 1'b1;

      // 1024/128 instance, size 900: marker at bit 123, length in extra block
      for (int i = 0; i < BW1/32; i++) w1[i*32 +: 32] = $urandom;
      e0 = '0;
      for (int k = 0; k < BW1; k++) e0[BW1-1-k] = (k < 900) ? w1[BW1-1-k] : (k == 900);
      e1 = '0;
      e1[LW1-1:0] = LW1'(900);
      @(negedge clk);
      u1_cfg_size = SW'(900); u1_cfg_valid = 1'b1;
      #1 chk("u1_cfg_ready", u1_cfg_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      u1_cfg_valid = 1'b0;
      u1_data_in = w1; u1_data_in_valid = 1'b1; u1_data_in_last = 1'b0;
      #1 chk("u1_in_ready", u1_data_in_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      u1_data_in_valid = 1'b0;
      #1;
      chk("u1_b0_valid", u1_data_out_valid, 1'b1);
      chk("u1_b0_hi", u1_data_out[1023:512], e0[1023:512]);
      chk("u1_b0_lo", u1_data_out[511:0], e0[511:0]);
      chk("u1_b0_last", u1_data_out_last, 1'b0);
`ifdef MSG_BUILD_LAST_CHECK_EN
      chk("u1_err_last", u1_err_last, 1'b1);
`endif
      cyc = 0;
      do begin
         @(negedge clk);
         #1;
         cyc++;
      end while (!u1_data_out_valid && cyc < 10);
      chk("u1_b1_valid", u1_data_out_valid, 1'b1);
      chk("u1_b1_hi", u1_data_out[1023:512], e1[1023:512]);
      chk("u1_b1_lo", u1_data_out[511:0], e1[511:0]);
      chk("u1_b1_last", u1_data_out_last, 1'b1);
      @(posedge clk);

      // directed sizes around boundaries, then random ones
      run_msg(440, 0);
      run_msg(1024, 2);
      run_msg(448, 0);
      run_msg(0, 2);
      run_msg(1536, 1);
      run_msg(1536, 2);
      run_msg(447, 2);
      run_msg(512, 0);
      run_msg(1, 0);
      run_msg(511, 1);
      for (int i = 0; i < 12; i++) run_msg(int'($urandom_range(0, 2048)), int'($urandom_range(0, 2)));
`ifdef MSG_BUILD_LAST_CHECK_EN
      chk("u0_err_last_clean", err_last, 1'b0);
`endif

      // async reset mid-message with a held output block
      @(negedge clk);
      cfg_size = SW'(1536); cfg_valid = 1'b1; data_out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      cfg_valid = 1'b0; data_in = rand_word(); data_in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      data_in_valid = 1'b0;
      #1;
      chk("held_valid", data_out_valid, 1'b1);
      chk("held_in_ready", data_in_ready, 1'b0);
      nrst = 1'b0;
      #1;
      chk("arst_data_out", data_out, '0);
      chk("arst_valid", data_out_valid, 1'b0);
      chk("arst_last", data_out_last, 1'b0);
      chk("arst_in_ready", data_in_ready, 1'b0);
      @(negedge clk);
      nrst = 1'b1; data_out_ready = 1'b1;
      #1 chk("arst_cfg_ready", cfg_ready, 1'b1);

      // synchronous clear mid-message
      @(negedge clk);
      cfg_size = SW'(1024); cfg_valid = 1'b1; data_out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      cfg_valid = 1'b0; data_in = rand_word(); data_in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      data_in_valid = 1'b0; sync_rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      sync_rst = 1'b0; data_out_ready = 1'b1;
      #1;
      chk("srst_data_out", data_out, '0);
      chk("srst_valid", data_out_valid, 1'b0);
      chk("srst_last", data_out_last, 1'b0);
      chk("srst_cfg_ready", cfg_ready, 1'b1);

      run_msg(440, 2);
      run_msg(900, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
